// File: rtl/execute.sv
// Execute stage: operand forwarding, 16-bit ALU, branch resolution,
// a shift-and-add multiplier that stalls upstream, and the EX/MEM registers.
//
// Handshake: busy is combinational. While busy=1 the upstream stage must keep
// every *_IDEX input stable, and each freeze=1 edge loads a bubble into EX/MEM.
// When busy=0, a freeze=1 edge accepts the instruction and loads its result.
// freeze=0 holds every register in this block.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [15:0] Rd1_IDEX,
  input  logic [15:0] Rd2_IDEX,
  input  logic [15:0] Imm_IDEX,
  input  logic [15:0] PCinc_IDEX,
  input  logic [2:0]  Rs_IDEX,
  input  logic [2:0]  Rt_IDEX,
  input  logic [2:0]  WrR_IDEX,
  input  logic [3:0]  ALUOp_IDEX,
  input  logic        ALUSrc_IDEX,
  input  logic [2:0]  BrCond_IDEX,
  input  logic        MemWrite_IDEX,
  input  logic        MemRead_IDEX,
  input  logic        MemtoReg_IDEX,
  input  logic        RegWrite_IDEX,
  input  logic        Dump_IDEX,
  input  logic        halt_IDEX,
  input  logic [15:0] WrD_MEMWB,
  input  logic [2:0]  WrR_MEMWB,
  input  logic        RegWrite_MEMWB,
  output logic        takeBranch,
  output logic [15:0] BrTarget,
  output logic        busy,
  output logic [15:0] ALUO_EXMEM,
  output logic [15:0] Rd2_EXMEM,
  output logic        takeBranch_EXMEM,
  output logic        MemWrite_EXMEM,
  output logic        MemRead_EXMEM,
  output logic        MemtoReg_EXMEM,
  output logic        RegWrite_EXMEM,
  output logic        Dump_EXMEM,
  output logic        halt_EXMEM,
  output logic [2:0]  WrR_EXMEM,
  output logic        o_dbg_state,
  output logic [3:0]  o_dbg_cnt
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_MULT = 1'b1;
  localparam logic [3:0] OP_MUL = 4'd14;

  logic        r_state;
  logic        w_next_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_prod;
  logic [15:0] r_ma;
  logic [15:0] r_mb;

  logic [15:0] w_fwd_a;
  logic [15:0] w_fwd_b;
  logic [15:0] w_op_b;
  logic [15:0] w_alu;
  logic [15:0] w_prod_next;
  logic [15:0] w_btr;
  logic [31:0] w_rol32;
  logic [31:0] w_ror32;
  logic [16:0] w_sum17;
  logic        w_ex_fwd_ok;
  logic        w_is_mul;

  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;
  assign w_is_mul    = (ALUOp_IDEX == OP_MUL);

  // A load result is not yet in ALUO_EXMEM, so EX/MEM only forwards ALU results.
  assign w_ex_fwd_ok = RegWrite_EXMEM && !MemtoReg_EXMEM;

  // Forwarding muxes: EX/MEM wins over MEM/WB, which wins over the register file.
  always_comb begin
    w_fwd_a = Rd1_IDEX;
    if (w_ex_fwd_ok && (WrR_EXMEM == Rs_IDEX))
      w_fwd_a = ALUO_EXMEM;
    else if (RegWrite_MEMWB && (WrR_MEMWB == Rs_IDEX))
      w_fwd_a = WrD_MEMWB;
  end

  // Same priority for the Rt operand / store data.
  always_comb begin
    w_fwd_b = Rd2_IDEX;
    if (w_ex_fwd_ok && (WrR_EXMEM == Rt_IDEX))
      w_fwd_b = ALUO_EXMEM;
    else if (RegWrite_MEMWB && (WrR_MEMWB == Rt_IDEX))
      w_fwd_b = WrD_MEMWB;
  end

  assign w_op_b  = ALUSrc_IDEX ? Imm_IDEX : w_fwd_b;
  assign w_rol32 = {w_fwd_a, w_fwd_a} << w_op_b[3:0];
  assign w_ror32 = {w_fwd_a, w_fwd_a} >> w_op_b[3:0];
  assign w_sum17 = {1'b0, w_fwd_a} + {1'b0, w_op_b};

  // Next partial product: add B shifted by the current bit index when that bit of A is set.
  assign w_prod_next = r_prod + (r_ma[r_cnt] ? (r_mb << r_cnt) : 16'h0000);

  // Bit-reverse of operand A.
  always_comb begin
    w_btr = 16'h0000;
    for (int i = 0; i < 16; i++) w_btr[i] = w_fwd_a[15 - i];
  end

  // ALU result; MUL is only meaningful on the last multiplier step.
  always_comb begin
    w_alu = 16'h0000;
    case (ALUOp_IDEX)
      4'd0:  w_alu = w_sum17[15:0];
      4'd1:  w_alu = w_fwd_a - w_op_b;
      4'd2:  w_alu = w_fwd_a & w_op_b;
      4'd3:  w_alu = w_fwd_a | w_op_b;
      4'd4:  w_alu = w_fwd_a ^ w_op_b;
      4'd5:  w_alu = w_fwd_a << w_op_b[3:0];
      4'd6:  w_alu = w_fwd_a >> w_op_b[3:0];
      4'd7:  w_alu = w_rol32[31:16];
      4'd8:  w_alu = w_ror32[15:0];
      4'd9:  w_alu = {15'd0, (w_fwd_a == w_op_b)};
      4'd10: w_alu = {15'd0, ($signed(w_fwd_a) <  $signed(w_op_b))};
      4'd11: w_alu = {15'd0, ($signed(w_fwd_a) <= $signed(w_op_b))};
      4'd12: w_alu = {15'd0, w_sum17[16]};
      4'd13: w_alu = w_op_b;
      4'd14: w_alu = w_prod_next;
      4'd15: w_alu = w_btr;
      default: w_alu = 16'h0000;
    endcase
  end

  // Branch decision on forwarded A; suppressed while the multiplier is running.
  always_comb begin
    takeBranch = 1'b0;
    case (BrCond_IDEX)
      3'b001:  takeBranch = (w_fwd_a == 16'h0000);
      3'b010:  takeBranch = (w_fwd_a != 16'h0000);
      3'b011:  takeBranch = w_fwd_a[15];
      3'b100:  takeBranch = !w_fwd_a[15];
      default: takeBranch = 1'b0;
    endcase
    if (r_state == S_MULT) takeBranch = 1'b0;
  end

  assign BrTarget = PCinc_IDEX + Imm_IDEX;

  // FSM state register: advances only on freeze=1 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_state <= S_IDLE;
    else if (freeze) r_state <= w_next_state;
  end

  // FSM next state: IDLE starts a multiply, MULT returns after the bit-15 step.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_is_mul) w_next_state = S_MULT;
      S_MULT:  if (r_cnt == 4'd15) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: stall upstream until the last multiplier step.
  always_comb begin
    busy = 1'b0;
    case (r_state)
      S_IDLE:  busy = w_is_mul;
      S_MULT:  busy = (r_cnt != 4'd15);
      default: busy = 1'b0;
    endcase
  end

  // Multiplier datapath: latch operands on entry, then one bit per freeze=1 edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_prod <= 16'h0000;
      r_ma   <= 16'h0000;
      r_mb   <= 16'h0000;
    end else if (freeze) begin
      if (r_state == S_IDLE) begin
        if (w_is_mul) begin
          r_ma   <= w_fwd_a;
          r_mb   <= w_op_b;
          r_prod <= 16'h0000;
          r_cnt  <= 4'd0;
        end
      end else begin
        r_prod <= w_prod_next;
        r_cnt  <= r_cnt + 4'd1;
      end
    end
  end

  // EX/MEM pipeline registers: bubble while busy, otherwise capture the instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUO_EXMEM       <= 16'h0000;
      Rd2_EXMEM        <= 16'h0000;
      takeBranch_EXMEM <= 1'b0;
      MemWrite_EXMEM   <= 1'b0;
      MemRead_EXMEM    <= 1'b0;
      MemtoReg_EXMEM   <= 1'b0;
      RegWrite_EXMEM   <= 1'b0;
      Dump_EXMEM       <= 1'b0;
      halt_EXMEM       <= 1'b0;
      WrR_EXMEM        <= 3'd0;
    end else if (freeze) begin
      if (busy) begin
        ALUO_EXMEM       <= 16'h0000;
        Rd2_EXMEM        <= 16'h0000;
        takeBranch_EXMEM <= 1'b0;
        MemWrite_EXMEM   <= 1'b0;
        MemRead_EXMEM    <= 1'b0;
        MemtoReg_EXMEM   <= 1'b0;
        RegWrite_EXMEM   <= 1'b0;
        Dump_EXMEM       <= 1'b0;
        halt_EXMEM       <= 1'b0;
        WrR_EXMEM        <= 3'd0;
      end else begin
        ALUO_EXMEM       <= w_alu;
        Rd2_EXMEM        <= w_fwd_b;
        takeBranch_EXMEM <= takeBranch;
        MemWrite_EXMEM   <= MemWrite_IDEX;
        MemRead_EXMEM    <= MemRead_IDEX;
        MemtoReg_EXMEM   <= MemtoReg_IDEX;
        RegWrite_EXMEM   <= RegWrite_IDEX;
        Dump_EXMEM       <= Dump_IDEX;
        halt_EXMEM       <= halt_IDEX;
        WrR_EXMEM        <= WrR_IDEX;
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: ALU table, forwarding, branches,
// multiplier timing with freeze gaps and reset abort.
`timescale 1ns/1ps
module tb_execute;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [15:0] Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCinc_IDEX;
  logic [2:0]  Rs_IDEX, Rt_IDEX, WrR_IDEX;
  logic [3:0]  ALUOp_IDEX;
  logic        ALUSrc_IDEX;
  logic [2:0]  BrCond_IDEX;
  logic        MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX;
  logic [15:0] WrD_MEMWB;
  logic [2:0]  WrR_MEMWB;
  logic        RegWrite_MEMWB;
  logic        takeBranch, busy;
  logic [15:0] BrTarget, ALUO_EXMEM, Rd2_EXMEM;
  logic        takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM;
  logic        RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM;
  logic [2:0]  WrR_EXMEM;
  logic        o_dbg_state;
  logic [3:0]  o_dbg_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  execute dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX), .Imm_IDEX(Imm_IDEX), .PCinc_IDEX(PCinc_IDEX),
    .Rs_IDEX(Rs_IDEX), .Rt_IDEX(Rt_IDEX), .WrR_IDEX(WrR_IDEX),
    .ALUOp_IDEX(ALUOp_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX), .BrCond_IDEX(BrCond_IDEX),
    .MemWrite_IDEX(MemWrite_IDEX), .MemRead_IDEX(MemRead_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX), .Dump_IDEX(Dump_IDEX), .halt_IDEX(halt_IDEX),
    .WrD_MEMWB(WrD_MEMWB), .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .takeBranch(takeBranch), .BrTarget(BrTarget), .busy(busy),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .takeBranch_EXMEM(takeBranch_EXMEM),
    .MemWrite_EXMEM(MemWrite_EXMEM), .MemRead_EXMEM(MemRead_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
    .RegWrite_EXMEM(RegWrite_EXMEM), .Dump_EXMEM(Dump_EXMEM), .halt_EXMEM(halt_EXMEM),
    .WrR_EXMEM(WrR_EXMEM), .o_dbg_state(o_dbg_state), .o_dbg_cnt(o_dbg_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ctrl_vec();
    return {9'd0, takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM,
            RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM};
  endfunction

  // Drive one instruction; memory/debug control bits default to 0.
  task automatic issue(input logic [3:0] op, input logic [15:0] rd1, input logic [15:0] rd2,
                       input logic [2:0] rs, input logic [2:0] rt, input logic alusrc,
                       input logic [15:0] imm, input logic [2:0] wrr, input logic regwrite,
                       input logic memtoreg, input logic [2:0] brcond);
    ALUOp_IDEX = op; Rd1_IDEX = rd1; Rd2_IDEX = rd2; Rs_IDEX = rs; Rt_IDEX = rt;
    ALUSrc_IDEX = alusrc; Imm_IDEX = imm; WrR_IDEX = wrr; RegWrite_IDEX = regwrite;
    MemtoReg_IDEX = memtoreg; BrCond_IDEX = brcond; PCinc_IDEX = 16'h0000;
    MemWrite_IDEX = 1'b0; MemRead_IDEX = 1'b0; Dump_IDEX = 1'b0; halt_IDEX = 1'b0;
  endtask

  // Run a presented MUL to completion; optional freeze=0 gap after gap_at edges.
  task automatic run_mul(input int gap_at, input int gap_len, output int n_busy,
                         output int n_edges, output int n_bad, output bit done);
    logic       was_busy;
    logic [3:0] held_cnt;
    n_busy = 0; n_edges = 0; n_bad = 0; done = 1'b0;
    while (!done && n_edges < 60) begin
      if (gap_len > 0 && n_edges == gap_at) begin
        check("mul_cnt_at_gap", {12'd0, o_dbg_cnt}, 16'd4);
        held_cnt = o_dbg_cnt;
        freeze = 1'b0;
        repeat (gap_len) begin
          tick();
          n_edges++;
          if (o_dbg_cnt != held_cnt || !o_dbg_state || ALUO_EXMEM != 0 || RegWrite_EXMEM) n_bad++;
        end
        freeze = 1'b1;
      end
      was_busy = busy;
      if (was_busy) n_busy++;
      tick();
      n_edges++;
      if (!was_busy) done = 1'b1;
      else if (RegWrite_EXMEM || ALUO_EXMEM != 0) n_bad++;
    end
  endtask

  localparam int NV = 17;
  // {op, a, b, expected}
  localparam logic [51:0] VEC [0:NV-1] = '{
    {4'd1,  16'h0003, 16'h0005, 16'hFFFE},
    {4'd2,  16'hF0F0, 16'h3C3C, 16'h3030},
    {4'd3,  16'hF0F0, 16'h0F00, 16'hFFF0},
    {4'd4,  16'hFFFF, 16'h1234, 16'hEDCB},
    {4'd5,  16'h0001, 16'h0014, 16'h0010},
    {4'd6,  16'h8000, 16'h000F, 16'h0001},
    {4'd7,  16'h8001, 16'h0001, 16'h0003},
    {4'd8,  16'h8001, 16'h0004, 16'h1800},
    {4'd9,  16'h1234, 16'h1234, 16'h0001},
    {4'd9,  16'h1234, 16'h1235, 16'h0000},
    {4'd10, 16'hFFFF, 16'h0001, 16'h0001},
    {4'd10, 16'h0001, 16'hFFFF, 16'h0000},
    {4'd11, 16'h0005, 16'h0005, 16'h0001},
    {4'd12, 16'hFFFF, 16'h0001, 16'h0001},
    {4'd12, 16'h7FFF, 16'h0001, 16'h0000},
    {4'd15, 16'h0003, 16'h0000, 16'hC000},
    {4'd13, 16'h1111, 16'hABCD, 16'hABCD}
  };

  initial begin
    logic [51:0] v;
    int nb, ne, bad;
    bit done;

    // Reset with activity on the inputs
    rst = 1'b1; freeze = 1'b1;
    issue(4'd0, 16'h7FFF, 16'h0001, 3'd1, 3'd2, 1'b0, 16'h0, 3'd3, 1'b1, 1'b0, 3'd0);
    WrD_MEMWB = 16'h0; WrR_MEMWB = 3'd0; RegWrite_MEMWB = 1'b0;
    tick(); tick();
    check("rst_aluo", ALUO_EXMEM, 16'h0000);
    check("rst_ctrl", ctrl_vec(), 16'h0000);
    check("rst_wrr", {13'd0, WrR_EXMEM}, 16'd0);
    check("rst_fsm", {11'd0, o_dbg_state, o_dbg_cnt}, 16'd0);
    rst = 1'b0;

    // ADD overflow wrap
    issue(4'd0, 16'h7FFF, 16'h0001, 3'd1, 3'd2, 1'b0, 16'h0, 3'd7, 1'b1, 1'b0, 3'd0);
    tick();
    check("add_7fff_1", ALUO_EXMEM, 16'h8000);
    check("add_regwrite", {15'd0, RegWrite_EXMEM}, 16'd1);

    // freeze=0 holds EX/MEM
    freeze = 1'b0;
    issue(4'd2, 16'h0000, 16'h0000, 3'd1, 3'd2, 1'b0, 16'h0, 3'd6, 1'b0, 1'b0, 3'd0);
    tick(); tick();
    check("freeze_hold_aluo", ALUO_EXMEM, 16'h8000);
    check("freeze_hold_wrr", {13'd0, WrR_EXMEM}, 16'd7);
    freeze = 1'b1;

    // ALU table (no forwarding: Rs=1, Rt=2, destination 7)
    for (int i = 0; i < NV; i++) begin
      v = VEC[i];
      issue(v[51:48], v[47:32], v[31:16], 3'd1, 3'd2, 1'b0, 16'h0, 3'd7, 1'b1, 1'b0, 3'd0);
      tick();
      check($sformatf("alu_op%0d_vec%0d", v[51:48], i), ALUO_EXMEM, v[15:0]);
    end

    // Forwarding: EX/MEM R3=5, MEM/WB R3=9
    WrD_MEMWB = 16'h0009; WrR_MEMWB = 3'd3; RegWrite_MEMWB = 1'b1;
    issue(4'd13, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, 16'h0005, 3'd3, 1'b1, 1'b0, 3'd0);
    tick();
    check("fwd_setup", ALUO_EXMEM, 16'h0005);
    issue(4'd13, 16'h1234, 16'h0, 3'd3, 3'd0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd1);
    #1;
    check("fwd_beqz_a5", {15'd0, takeBranch}, 16'd0);
    tick();
    check("fwd_passb_imm0", ALUO_EXMEM, 16'h0000);
    issue(4'd13, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, 16'h0005, 3'd3, 1'b1, 1'b0, 3'd0);
    tick();
    issue(4'd0, 16'h1234, 16'h4321, 3'd3, 3'd3, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0);
    tick();
    check("fwd_a_exmem_prio", ALUO_EXMEM, 16'h0005);
    check("fwd_b_exmem_store", Rd2_EXMEM, 16'h0005);
    tick();
    check("fwd_a_memwb", ALUO_EXMEM, 16'h0009);
    check("fwd_b_memwb_store", Rd2_EXMEM, 16'h0009);
    issue(4'd13, 16'h0, 16'h0, 3'd0, 3'd0, 1'b1, 16'h0005, 3'd3, 1'b1, 1'b1, 3'd0);
    tick();
    issue(4'd0, 16'h1234, 16'h0, 3'd3, 3'd0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 3'd0);
    tick();
    check("fwd_load_not_from_exmem", ALUO_EXMEM, 16'h0009);
    RegWrite_MEMWB = 1'b0;
    tick();
    check("fwd_none_regfile", ALUO_EXMEM, 16'h1234);

    // Branches and control pass-through
    issue(4'd0, 16'h8000, 16'h00AA, 3'd1, 3'd2, 1'b0, 16'hFFFC, 3'd4, 1'b0, 1'b0, 3'd3);
    PCinc_IDEX = 16'h0010; MemWrite_IDEX = 1'b1; MemRead_IDEX = 1'b1;
    Dump_IDEX = 1'b1; halt_IDEX = 1'b1;
    #1;
    check("bltz_taken", {15'd0, takeBranch}, 16'd1);
    check("br_target", BrTarget, 16'h000C);
    tick();
    check("bltz_ctrl_exmem", ctrl_vec(), 16'b111_0011);
    check("bltz_wrr", {13'd0, WrR_EXMEM}, 16'd4);
    check("bltz_store", Rd2_EXMEM, 16'h00AA);
    issue(4'd0, 16'h8000, 16'h0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd4, 1'b0, 1'b0, 3'd4);
    #1;
    check("bgez_neg", {15'd0, takeBranch}, 16'd0);
    issue(4'd0, 16'h0000, 16'h0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd4, 1'b0, 1'b0, 3'd2);
    #1;
    check("bnez_zero", {15'd0, takeBranch}, 16'd0);
    issue(4'd0, 16'h0000, 16'h0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd4, 1'b0, 1'b0, 3'd7);
    #1;
    check("brcond_other", {15'd0, takeBranch}, 16'd0);
    tick();

    // MUL 0x0123 * 0x0010
    issue(4'd14, 16'h0123, 16'h0010, 3'd1, 3'd2, 1'b0, 16'h0, 3'd5, 1'b1, 1'b0, 3'd1);
    #1;
    check("mul_busy_idle", {15'd0, busy}, 16'd1);
    run_mul(0, 0, nb, ne, bad, done);
    issue(4'd0, 16'h0, 16'h0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd7, 1'b0, 1'b0, 3'd0);
    check("mul_done", {15'd0, done}, 16'd1);
    check("mul_busy_cycles", nb[15:0], 16'd16);
    check("mul_latency", ne[15:0], 16'd17);
    check("mul_bubbles", bad[15:0], 16'd0);
    check("mul_result", ALUO_EXMEM, 16'h1230);
    check("mul_regwrite", {15'd0, RegWrite_EXMEM}, 16'd1);
    check("mul_wrr", {13'd0, WrR_EXMEM}, 16'd5);
    check("mul_back_idle", {15'd0, o_dbg_state}, 16'd0);

    // MUL with a 3-cycle freeze gap
    issue(4'd14, 16'h0123, 16'h0010, 3'd1, 3'd2, 1'b0, 16'h0, 3'd5, 1'b1, 1'b0, 3'd0);
    run_mul(5, 3, nb, ne, bad, done);
    issue(4'd0, 16'h0, 16'h0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd7, 1'b0, 1'b0, 3'd0);
    check("mulgap_done", {15'd0, done}, 16'd1);
    check("mulgap_busy_cycles", nb[15:0], 16'd16);
    check("mulgap_latency", ne[15:0], 16'd20);
    check("mulgap_hold", bad[15:0], 16'd0);
    check("mulgap_result", ALUO_EXMEM, 16'h1230);

    // Reset pulse at counter 7 aborts the multiply
    tick();
    issue(4'd14, 16'h0123, 16'h0010, 3'd1, 3'd2, 1'b0, 16'h0, 3'd5, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 30 && !(o_dbg_state && o_dbg_cnt == 4'd7); i++) tick();
    check("mulrst_reach_cnt7", {11'd0, o_dbg_state, o_dbg_cnt}, 16'h0017);
    rst = 1'b1;
    #2;
    check("mulrst_async_fsm", {11'd0, o_dbg_state, o_dbg_cnt}, 16'd0);
    check("mulrst_aluo", ALUO_EXMEM, 16'h0000);
    check("mulrst_ctrl", ctrl_vec(), 16'h0000);
    tick();
    issue(4'd0, 16'h0001, 16'h0002, 3'd1, 3'd2, 1'b0, 16'h0, 3'd6, 1'b1, 1'b0, 3'd0);
    rst = 1'b0;
    #1;
    check("postrst_busy", {15'd0, busy}, 16'd0);
    tick();
    check("postrst_add", ALUO_EXMEM, 16'h0003);
    check("postrst_wrr", {13'd0, WrR_EXMEM}, 16'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 clk  in  1  stage clock; all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 freeze  in  1  stage enable: 1 = EX/MEM registers and FSM advance; 0 = all state holds.
REQ-004 Rd1_IDEX, Rd2_IDEX  in  16 each  register-file read data for Rs and Rt.
REQ-005 Imm_IDEX, PCinc_IDEX  in  16 each  extended immediate; PC+2 of the instruction.
REQ-006 Rs_IDEX, Rt_IDEX, WrR_IDEX  in  3 each  source and destination register numbers.
REQ-007 ALUOp_IDEX  in  4  operation select (encoding in REQ-024).
REQ-008 ALUSrc_IDEX  in  1  1 = operand B is Imm_IDEX.
REQ-009 BrCond_IDEX  in  3  000 none, 001 BEQZ, 010 BNEZ, 011 BLTZ, 100 BGEZ; others are treated as none.
REQ-010 MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX  in  1 each  control bits.
REQ-011 WrD_MEMWB  in  16  writeback data, used for forwarding.
REQ-012 WrR_MEMWB  in  3  writeback destination register.
REQ-013 RegWrite_MEMWB  in  1  writeback write enable.
REQ-014 takeBranch  out  1  combinational branch-taken flag.
REQ-015 BrTarget  out  16  combinational branch target, PCinc_IDEX + Imm_IDEX modulo 2^16.
REQ-016 busy  out  1  combinational; 1 = upstream holds ID/EX stable.
REQ-017 ALUO_EXMEM, Rd2_EXMEM  out  16 each  registered ALU result and registered store data.
REQ-018 takeBranch_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM  out  1 each  registered control bits.
REQ-019 WrR_EXMEM  out  3  registered destination register.

Function
REQ-020 Forwarding for operand A (Rs) shall use this priority:
- EX/MEM match (RegWrite_EXMEM=1, MemtoReg_EXMEM=0, WrR_EXMEM=Rs_IDEX): ALUO_EXMEM.
- else MEM/WB match (RegWrite_MEMWB=1, WrR_MEMWB=Rs_IDEX): WrD_MEMWB.
- else Rd1_IDEX.
REQ-021 Forwarded Rt value (fwdB) shall use the same priority against Rt_IDEX; its base value is Rd2_IDEX.
REQ-022 Load-use hazards are resolved upstream; this block inserts no load stall.
REQ-023 Operand B shall be Imm_IDEX when ALUSrc_IDEX=1, else fwdB.
REQ-024 ALUOp encoding:
- 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
- 5 SLL, 6 SRL, 7 ROL, 8 ROR; shift amount is B[3:0].
- 9 SEQ, 10 SLT (signed), 11 SLE (signed), 12 SCO (carry out of A+B).
- 13 PASSB, 14 MUL, 15 BTR (bit-reverse A).
REQ-025 All results shall be 16 bits, wrap modulo 2^16; set-ops produce 16'h0001 or 16'h0000.
REQ-026 takeBranch shall be the BrCond_IDEX condition evaluated on forwarded A (signed for BLTZ/BGEZ), and 0 while in MULT state.
REQ-027 When freeze=1 and busy=0, EX/MEM shall load:
- ALU result into ALUO_EXMEM and fwdB into Rd2_EXMEM;
- takeBranch into takeBranch_EXMEM;
- all IDEX control bits and WrR_IDEX into their EX/MEM counterparts.
REQ-028 When freeze=1 and busy=1, EX/MEM shall load a bubble: all control bits 0, WrR_EXMEM 0, ALUO_EXMEM 0, Rd2_EXMEM 0.
REQ-029 MUL FSM states are IDLE and MULT, with a 4-bit counter.
REQ-030 IDLE with ALUOp_IDEX=14: busy=1; on a freeze=1 edge, latch A and B, clear the product and counter, go to MULT.
REQ-031 MULT: each freeze=1 edge adds (B<<counter) to the product when A[counter]=1, then increments the counter.
REQ-032 MULT with counter <15: busy=1.
REQ-033 MULT with counter=15: busy=0; the final product (low 16 bits) and the MUL's control bits load into EX/MEM; the FSM returns to IDLE.
REQ-034 MUL timing: busy is high for exactly 16 freeze=1 cycles; the result appears in EX/MEM 17 freeze=1 edges after presentation.
REQ-035 With freeze=0, FSM state, counter, product and all EX/MEM registers shall hold.

Reset
REQ-036 While rst=1, all EX/MEM outputs shall be 0, the FSM IDLE, counter 0 and product 0, regardless of clk.
REQ-037 Reset asserted during MULT shall abort the multiply; no result is written.

Verification
REQ-038 ADD: Rd1=16'h7FFF, Rd2=1, ALUOp=0, freeze=1 -> ALUO_EXMEM=16'h8000 after one edge.
REQ-039 Forwarding: EX/MEM writes R3=16'h0005, MEM/WB writes R3=16'h0009, Rs=3, ALUOp=13, ALUSrc=1, Imm=0 -> ALUO_EXMEM=0; BEQZ on Rs=3 -> takeBranch=0 (A=5).
REQ-040 BLTZ: A=16'h8000, PCinc=16'h0010, Imm=16'hFFFC -> takeBranch=1, BrTarget=16'h000C.
REQ-041 MUL: A=16'h0123, B=16'h0010 -> busy high 16 cycles, bubbles in EX/MEM, then ALUO_EXMEM=16'h1230 with RegWrite_EXMEM=1.
REQ-042 Freeze and reset during MUL: freeze=0 for 3 cycles mid-MUL -> counter and outputs hold, result delayed exactly 3 cycles; rst pulse at counter=7 -> IDLE, all outputs 0.
